queue_buffer: RTL and testbench
===============================

Name: queue_buffer

Overview:
- Synchronous FIFO queue buffer: the first-in-first-out counterpart to the team's LIFO stack buffer.
- Writes enter at the tail; reads leave from the head, which is the opposite end.
- Keeps the stack's port vocabulary (buf_in/buf_out, push/pop, empty/full/size/error), so the two buffers are drop-in alternatives in datapath staging.
- Unlike the stack, push and pop in the same cycle are legal and not an error.

Parameters:
- DATA_W, 8, width of buf_in/buf_out in bits.
- DEPTH, 16, number of entries; must be a power of two, at least 2.
- ADDR_W, $clog2(DEPTH), pointer width. Derived; not overridden.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- buf_in  input  DATA_W  write data, sampled when a push is accepted.
- push  input  1  write request.
- pop  input  1  read request.
- buf_out  output  DATA_W  registered read data.
- valid_out  output  1  one-cycle pulse: buf_out was loaded by the previous accepted pop.
- empty  output  1  registered; high when size == 0.
- full  output  1  registered; high when size == DEPTH.
- size  output  ADDR_W+1  registered entry count, 0..DEPTH.
- error  output  1  registered one-cycle pulse on a rejected request.

Behaviour:
- Reset (async, immediate):
  - rd_ptr = 0, wr_ptr = 0, size = 0.
  - empty = 1, full = 0, error = 0, buf_out = 0, valid_out = 0.
  - Memory contents are not reset and are don't-care.
- Accept rules, evaluated on registered state:
  - rd_acc = pop & ~empty.
  - wr_acc = push & (~full | rd_acc).
  - Push on full is accepted only when a pop is accepted in the same cycle.
- Write: on wr_acc, mem[wr_ptr] <= buf_in and wr_ptr <= wr_ptr+1.
- Read:
  - On rd_acc, buf_out <= mem[rd_ptr], rd_ptr <= rd_ptr+1, and valid_out <= 1 on the next cycle.
  - Otherwise buf_out holds its last value (no tri-state) and valid_out <= 0.
- Pointer wrap: both pointers are ADDR_W bits and wrap modulo DEPTH naturally (DEPTH-1 -> 0).
- Size update:
  - wr_acc & ~rd_acc: size+1.
  - rd_acc & ~wr_acc: size-1.
  - Both or neither: unchanged.
- Flags: empty_next = (size_next == 0); full_next = (size_next == DEPTH). Both are registered alongside size.
- Simultaneous push+pop:
  - Non-empty: both execute. The read returns the oldest entry, never the word being written. Size is unchanged.
  - Empty: push only; pop is rejected and error pulses. No fall-through: data written this cycle is readable from the next cycle.
  - Full: both execute; full stays 1.
- Error, a one-cycle pulse on the next edge, asserted when:
  - pop & empty (underflow), or
  - push & full & ~rd_acc (overflow).
  - A rejected request changes no state.
  - If one request of a simultaneous pair is rejected, the other still executes.
- Latency:
  - Pop to data: 1 cycle.
  - Push to visible in size/empty: 1 cycle.
  - A push at cycle t is poppable at t+1.
- Reset mid-operation: all state returns to reset values asynchronously. Entries in flight are lost, with no error pulse. A pending valid_out is cleared.
- No combinational path from inputs to outputs.

Decomposition:
- No shared package is required.
- DATA_W/DEPTH defaults match the stack buffer. If a buffer_pkg exists, its DEPTH/DATA_W constants are reused.
- One natural sub-module: queue_mem, a simple dual-port register array.
  - Write port: we, waddr, wdata.
  - Synchronous read port: re, raddr, rdata register.
  - It keeps storage separable from pointer/flag control.
- Control logic (pointers, size, flags, error) lives in queue_buffer.

Test Plan:
- Reset then idle: after rst pulse, empty=1, full=0, size=0, error=0, buf_out=0, valid_out=0, and they hold for 5 idle cycles.
- Order check: push 0x11,0x22,0x33, then pop x3 → buf_out 0x11,0x22,0x33 on successive cycles, each with valid_out=1. size goes 1,2,3,2,1,0 and empty=1 at end.
- Fill and overflow: push 0x00..0x0F (16 words) → full=1, size=16. A 17th push 0xAA → error pulses once, size stays 16. Then 16 pops return 0x00..0x0F; 0xAA never appears.
- Underflow: pop on empty → error=1 for one cycle, valid_out=0, buf_out unchanged, size=0.
- Simultaneous ops:
  - Push+pop with size=3 (oldest 0x11) → buf_out=0x11, size stays 3.
  - Push+pop while full → both accepted, full stays 1, no error.
  - Push+pop while empty → error, size=1.
- Wrap and async reset:
  - Stream 40 words through with interleaved push/pop, crossing the pointer wrap twice → output order matches a reference queue model.
  - Assert rst mid-stream between clock edges → outputs hit reset values immediately, before the next edge.

Source files
------------

// File: rtl/queue_buffer_pkg.sv
// Shared defaults for the queue buffer. They match the stack buffer so the two
// can be swapped in datapath staging without touching parameters.
package queue_buffer_pkg;
   localparam int QB_DATA_W = 8;
   localparam int QB_DEPTH  = 16;
endpackage

// File: rtl/queue_mem.sv
// Simple dual-port register array: one write port plus a registered read port.
// Storage is kept apart from the pointer/flag control in queue_buffer.
module queue_mem
   import queue_buffer_pkg::*;
#(
   parameter  int DATA_W = QB_DATA_W,
   parameter  int DEPTH  = QB_DEPTH,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // NOTE: the array has no reset; its contents are don't-care until written,
   // and leaving it out of the reset lets it map onto plain flops or RAM.
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   // NOTE: non-blocking assignment means a read of the address being written
   // in the same cycle returns the old word, never the incoming one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       rdata_q <= '0;
      else if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/queue_buffer.sv
// Synchronous FIFO with the stack buffer's port vocabulary. Push and pop in the
// same cycle are legal; every output is registered.
module queue_buffer
   import queue_buffer_pkg::*;
#(
   parameter  int DATA_W = QB_DATA_W,
   parameter  int DEPTH  = QB_DEPTH,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] buf_in,
   input  logic              push,
   input  logic              pop,
   output logic [DATA_W-1:0] buf_out,
   output logic              valid_out,
   output logic              empty,
   output logic              full,
   output logic [ADDR_W:0]   size,
   output logic              error
);
   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

   logic [ADDR_W-1:0] rd_ptr_q, wr_ptr_q;
   logic [ADDR_W:0]   size_q, size_d;
   logic              empty_q, full_q, error_q, valid_q;
   logic              rd_acc, wr_acc, error_d;

   // A push on full is only taken when a pop frees the slot in the same cycle.
   assign rd_acc  = pop & ~empty_q;
   assign wr_acc  = push & (~full_q | rd_acc);
   assign error_d = (pop & empty_q) | (push & full_q & ~rd_acc);

   // NOTE: size_d gets a default before the branches so no latch is inferred.
   always_comb begin
      size_d = size_q;
      if (wr_acc && !rd_acc)      size_d = size_q + 1'b1;
      else if (rd_acc && !wr_acc) size_d = size_q - 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         size_q   <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         error_q  <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd_acc) rd_ptr_q <= rd_ptr_q + 1'b1;
         size_q  <= size_d;
         empty_q <= (size_d == '0);
         full_q  <= (size_d == FULL_CNT);
         error_q <= error_d;
         valid_q <= rd_acc;
      end
   end

   queue_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .we_i    (wr_acc),
      .waddr_i (wr_ptr_q),
      .wdata_i (buf_in),
      .re_i    (rd_acc),
      .raddr_i (rd_ptr_q),
      .rdata_o (buf_out)
   );

   assign valid_out = valid_q;
   assign empty     = empty_q;
   assign full      = full_q;
   assign size      = size_q;
   assign error     = error_q;
endmodule

// File: tb/tb_queue_buffer.sv
// Directed bench for queue_buffer: ordering, overflow/underflow, simultaneous
// push/pop, pointer wrap against a reference queue, and async reset.
module tb_queue_buffer;
   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] buf_in;
   logic       push, pop;
   logic [7:0] buf_out;
   logic       valid_out, empty, full, error;
   logic [4:0] size;

   int total  = 0;
   int passed = 0;

   queue_buffer #(.DATA_W(8), .DEPTH(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .buf_in    (buf_in),
      .push      (push),
      .pop       (pop),
      .buf_out   (buf_out),
      .valid_out (valid_out),
      .empty     (empty),
      .full      (full),
      .size      (size),
      .error     (error)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // One clock: drive request, take the edge, sample 1 ns later.
   task automatic cyc(input logic p, input logic q, input logic [7:0] d);
      push = p; pop = q; buf_in = d;
      @(posedge clk); #1;
      push = 1'b0; pop = 1'b0;
   endtask

   task automatic status(input string tag, input int sz, input logic e, input logic f,
                         input logic er);
      check({tag, ".size"},  32'(size),  32'(sz));
      check({tag, ".empty"}, 32'(empty), 32'(e));
      check({tag, ".full"},  32'(full),  32'(f));
      check({tag, ".error"}, 32'(error), 32'(er));
   endtask

   task automatic popped(input string tag, input logic [7:0] d);
      check({tag, ".buf_out"},   32'(buf_out),   32'(d));
      check({tag, ".valid_out"}, 32'(valid_out), 32'd1);
   endtask

   logic [7:0] model_q [$];
   logic [7:0] exp_d;
   int         n_push;
   int         cycles;
   logic       do_push, do_pop;

   initial begin
      rst = 1'b1; push = 1'b0; pop = 1'b0; buf_in = '0;
      #12 rst = 1'b0;

      // Reset then idle
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, 1'b0, 8'h00);
         status("idle", 0, 1'b1, 1'b0, 1'b0);
         check("idle.buf_out",   32'(buf_out),   32'h0);
         check("idle.valid_out", 32'(valid_out), 32'h0);
      end

      // Order check
      cyc(1'b1, 1'b0, 8'h11); status("ord.p1", 1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 8'h22); status("ord.p2", 2, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 8'h33); status("ord.p3", 3, 1'b0, 1'b0, 1'b0);
      check("ord.no_valid", 32'(valid_out), 32'h0);
      cyc(1'b0, 1'b1, 8'h00); popped("ord.r1", 8'h11); status("ord.r1", 2, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 8'h00); popped("ord.r2", 8'h22); status("ord.r2", 1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 8'h00); popped("ord.r3", 8'h33); status("ord.r3", 0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 8'h00);
      check("ord.valid_drop", 32'(valid_out), 32'h0);
      check("ord.hold",       32'(buf_out),   32'h33);

      // Fill and overflow
      for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(i));
      status("fill", 16, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 8'hAA);
      status("ovf", 16, 1'b0, 1'b1, 1'b1);
      cyc(1'b0, 1'b0, 8'h00);
      check("ovf.pulse_end", 32'(error), 32'h0);
      for (int i = 0; i < 16; i++) begin
         cyc(1'b0, 1'b1, 8'h00);
         popped("drain", 8'(i));
      end
      status("drained", 0, 1'b1, 1'b0, 1'b0);

      // Underflow
      cyc(1'b0, 1'b1, 8'h00);
      status("udf", 0, 1'b1, 1'b0, 1'b1);
      check("udf.valid_out", 32'(valid_out), 32'h0);
      check("udf.buf_out",   32'(buf_out),   32'h0F);
      cyc(1'b0, 1'b0, 8'h00);
      check("udf.pulse_end", 32'(error), 32'h0);

      // Simultaneous push+pop, non-empty
      cyc(1'b1, 1'b0, 8'h11); cyc(1'b1, 1'b0, 8'h22); cyc(1'b1, 1'b0, 8'h33);
      cyc(1'b1, 1'b1, 8'h44);
      popped("sim3", 8'h11);
      status("sim3", 3, 1'b0, 1'b0, 1'b0);
      // Fill to 16 then push+pop while full
      for (int i = 0; i < 13; i++) cyc(1'b1, 1'b0, 8'h50 + 8'(i));
      status("sim.full", 16, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 8'h99);
      popped("simfull", 8'h22);
      status("simfull", 16, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 8'h00); popped("simd0", 8'h33);
      cyc(1'b0, 1'b1, 8'h00); popped("simd1", 8'h44);
      for (int i = 0; i < 13; i++) begin
         cyc(1'b0, 1'b1, 8'h00);
         popped("simd", 8'h50 + 8'(i));
      end
      cyc(1'b0, 1'b1, 8'h00); popped("simd_last", 8'h99);
      status("simd_end", 0, 1'b1, 1'b0, 1'b0);
      // Push+pop while empty: push only, pop rejected
      cyc(1'b1, 1'b1, 8'h77);
      status("simempty", 1, 1'b0, 1'b0, 1'b1);
      check("simempty.valid_out", 32'(valid_out), 32'h0);
      cyc(1'b0, 1'b1, 8'h00);
      popped("simempty.r", 8'h77);
      status("simempty.r", 0, 1'b1, 1'b0, 1'b0);

      // Stream 40 words through interleaved push/pop against a reference queue
      n_push = 0;
      cycles = 0;
      while ((n_push < 40 || model_q.size() > 0) && cycles < 400) begin
         do_push = (n_push < 40) && (cycles % 3 != 2);
         do_pop  = (model_q.size() > 0) && ((cycles % 2 == 1) || n_push == 40);
         exp_d = 8'h00;
         if (do_pop) exp_d = model_q.pop_front();
         if (do_push) begin
            model_q.push_back(8'hC0 ^ 8'(n_push * 7));
            n_push++;
         end
         cyc(do_push, do_pop, 8'hC0 ^ 8'(n_push * 7 - 7));
         if (do_pop) popped("stream", exp_d);
         else check("stream.valid_out", 32'(valid_out), 32'h0);
         check("stream.size",  32'(size),  32'(model_q.size()));
         check("stream.error", 32'(error), 32'h0);
         cycles++;
      end
      check("stream.done", 32'(n_push == 40 && model_q.size() == 0), 32'h1);

      // Async reset mid-operation, between clock edges
      cyc(1'b1, 1'b0, 8'h5A); cyc(1'b1, 1'b0, 8'hA5);
      cyc(1'b0, 1'b1, 8'h00);
      popped("pre_rst", 8'h5A);
      #2 rst = 1'b1;
      #1;
      status("async_rst", 0, 1'b1, 1'b0, 1'b0);
      check("async_rst.buf_out",   32'(buf_out),   32'h0);
      check("async_rst.valid_out", 32'(valid_out), 32'h0);
      #3 rst = 1'b0;
      cyc(1'b0, 1'b0, 8'h00);
      status("post_rst", 0, 1'b1, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
